dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, posted-write buffer entries (power of 2, >=2).
REQ-002 SHALL have ports, one per line: clk in 1 clock; rst in 1 reset.
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Pipeline side: MemRW_pype2 in 2 ([1]=load, [0]=store); daddr in 32 word address; dwdata in 32 store data; dbe in 4 byte enables; stall_Mem in 1 Mem-stage hold; dready_n out 1 load-not-ready (active-low); dbusy out 1 store-buffer-full; drdata out 32 load data.
REQ-005 Memory side: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_be out 4; mem_ack in 1 single-cycle completion; mem_rdata in 32, valid with mem_ack.

Function
REQ-006 SHALL implement FSM states IDLE, DRAIN, READ, RESP.
REQ-007 Store accept: MemRW_pype2==01, dbusy==0, wr_taken==0 -> enqueue {daddr,dwdata,dbe} at the clock edge.
REQ-008 A store accepted while stall_Mem==1 SHALL set wr_taken; wr_taken SHALL block re-enqueue of the held store and clear on the first cycle with stall_Mem==0.
REQ-009 dbusy SHALL be registered and equal (count==WBUF_DEPTH).
REQ-010 Simultaneous enqueue and dequeue SHALL leave count unchanged; no enqueue when full, no dequeue when empty.
REQ-011 IDLE, buffer non-empty, no load pending -> DRAIN: mem_req=1, mem_we=1, head entry on mem_addr/mem_wdata/mem_be, held stable until mem_ack.
REQ-012 DRAIN on mem_ack -> pop head; next state DRAIN if count after pop >0 and no load pending, else IDLE.
REQ-013 Load (MemRW_pype2==10, state IDLE, not in RESP) SHALL wait until buffer empty, then enter READ: mem_req=1, mem_we=0, mem_addr=daddr, mem_be=4'b1111.
REQ-014 READ on mem_ack -> drdata<=mem_rdata, RESP.
REQ-015 RESP: dready_n=0 and drdata held while stall_Mem==1; first cycle with stall_Mem==0 -> dready_n=1, IDLE.
REQ-016 dready_n SHALL be 1 in every state except RESP, including while a load waits on the buffer.
REQ-017 A load arriving during DRAIN SHALL take priority over further drains, but only once the buffer is empty; in-flight store completes first.
REQ-018 MemRW_pype2==11 or 00 SHALL be ignored (no enqueue, no read).
REQ-019 mem_req SHALL never drop before mem_ack; at most one memory transaction outstanding.
REQ-020 Load latency (empty buffer, ack in N cycles after mem_req) SHALL be N+1 cycles from load presentation to dready_n==0.

Reset
REQ-021 rst SHALL asynchronously force: state IDLE, count 0, buffer pointers 0, wr_taken 0, dready_n 1, dbusy 0, drdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0.
REQ-022 Reset mid-transaction SHALL discard buffered stores and the outstanding request; a later mem_ack SHALL be ignored in IDLE.

Configuration
REQ-023 Macro DMEM_WBUF_FWD_EN defined: a load whose address matches a buffered entry with dbe==1111 SHALL return the youngest matching data, enter RESP the next cycle, and issue no memory read; a partial-byte match SHALL wait for buffer drain.
REQ-024 Macro DMEM_WBUF_FWD_EN undefined: every load SHALL wait for an empty buffer (REQ-013); no address comparison logic.

Verification
REQ-025 Store 0x100<=0xDEADBEEF, mem_ack 2 cycles later -> one mem write with those values, count returns 0, dbusy never 1.
REQ-026 Three back-to-back stores, mem_ack withheld, WBUF_DEPTH=2 -> dbusy=1 after second enqueue, third enqueued only after first mem_ack, exactly 3 writes in order.
REQ-027 Load 0x200, empty buffer, mem_rdata=0x12345678 on ack after 3 cycles -> dready_n=0 at cycle 4, drdata=0x12345678.
REQ-028 Store held with stall_Mem=1 for 5 cycles -> exactly one enqueue; load held in RESP with stall_Mem=1 -> dready_n stays 0, data stable.
REQ-029 Store 0x300<=0xA5A5A5A5 (full bytes) then load 0x300, ack withheld -> with DMEM_WBUF_FWD_EN: drdata=0xA5A5A5A5, no read issued; without: read issued after write ack.
REQ-030 rst asserted during READ -> all outputs at reset values within same cycle; stale mem_ack ignored; next load starts fresh.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Pipeline-to-data-memory bundle: Mem-stage request/response plus the memory-side handshake.
interface dmem_responder_if;
  logic [1:0]  MemRW_pype2;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        stall_Mem;
  logic        dready_n;
  logic        dbusy;
  logic [31:0] drdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  MemRW_pype2, daddr, dwdata, dbe, stall_Mem, mem_ack, mem_rdata,
    output dready_n, dbusy, drdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output MemRW_pype2, daddr, dwdata, dbe, stall_Mem, mem_ack, mem_rdata,
    input  dready_n, dbusy, drdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: posted-write buffer drained to memory, loads wait for an empty buffer.
// Define DMEM_WBUF_FWD_EN to forward full-word buffered stores to matching loads.
//   state | meaning
//   IDLE  | waiting for a load or for buffered stores to drain
//   DRAIN | buffer head written to memory, waiting for mem_ack
//   READ  | load read outstanding, waiting for mem_ack
//   RESP  | load data presented, held while stall_Mem
module dmem_responder #(
  parameter int WBUF_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

  state_t        r_state, w_state_nx;
  logic [31:0]   r_buf_addr [WBUF_DEPTH];
  logic [31:0]   r_buf_data [WBUF_DEPTH];
  logic [3:0]    r_buf_be   [WBUF_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr, w_rptr_inc;
  logic [CW-1:0] r_count, w_count_nx;
  logic          r_wr_taken, r_dbusy;
  logic          r_dready_n, w_dready_n_nx;
  logic [31:0]   r_drdata, w_drdata_nx;
  logic          r_mem_req, w_mem_req_nx;
  logic          r_mem_we, w_mem_we_nx;
  logic [31:0]   r_mem_addr, w_mem_addr_nx;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nx;
  logic [3:0]    r_mem_be, w_mem_be_nx;
  logic          w_enq, w_deq, w_load;

  assign w_enq      = (bus.MemRW_pype2 == 2'b01) && !r_dbusy && !r_wr_taken;
  assign w_deq      = (r_state == DRAIN) && bus.mem_ack;
  assign w_load     = (bus.MemRW_pype2 == 2'b10);
  assign w_count_nx = r_count + CW'(w_enq) - CW'(w_deq);
  assign w_rptr_inc = r_rptr + AW'(1);

`ifdef DMEM_WBUF_FWD_EN
  logic          w_fwd_hit, w_fwd_full;
  logic [31:0]   w_fwd_data;
  logic [AW-1:0] w_idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_full = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      w_idx = r_rptr + AW'(i);
      if ((CW'(i) < r_count) && (r_buf_addr[w_idx] == bus.daddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_full = (r_buf_be[w_idx] == 4'b1111);
        w_fwd_data = r_buf_data[w_idx];
      end
    end
  end
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_dready_n_nx  = r_dready_n;
    w_drdata_nx    = r_drdata;
    w_mem_req_nx   = r_mem_req;
    w_mem_we_nx    = r_mem_we;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_mem_be_nx    = r_mem_be;
    case (r_state)
      IDLE: begin
`ifdef DMEM_WBUF_FWD_EN
        if (w_load && w_fwd_hit && w_fwd_full) begin
          w_state_nx    = RESP;
          w_dready_n_nx = 1'b0;
          w_drdata_nx   = w_fwd_data;
        end else
`endif
        if (w_load && (r_count == '0)) begin
          w_state_nx    = READ;
          w_mem_req_nx  = 1'b1;
          w_mem_we_nx   = 1'b0;
          w_mem_addr_nx = bus.daddr;
          w_mem_be_nx   = 4'b1111;
        end else if (r_count != '0) begin
          w_state_nx     = DRAIN;
          w_mem_req_nx   = 1'b1;
          w_mem_we_nx    = 1'b1;
          w_mem_addr_nx  = r_buf_addr[r_rptr];
          w_mem_wdata_nx = r_buf_data[r_rptr];
          w_mem_be_nx    = r_buf_be[r_rptr];
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          if ((w_count_nx != '0) && !w_load) begin
            // With one entry left the next head is the store being enqueued right now.
            if (r_count == CW'(1)) begin
              w_mem_addr_nx  = bus.daddr;
              w_mem_wdata_nx = bus.dwdata;
              w_mem_be_nx    = bus.dbe;
            end else begin
              w_mem_addr_nx  = r_buf_addr[w_rptr_inc];
              w_mem_wdata_nx = r_buf_data[w_rptr_inc];
              w_mem_be_nx    = r_buf_be[w_rptr_inc];
            end
          end else begin
            w_state_nx   = IDLE;
            w_mem_req_nx = 1'b0;
          end
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          w_state_nx    = RESP;
          w_mem_req_nx  = 1'b0;
          w_drdata_nx   = bus.mem_rdata;
          w_dready_n_nx = 1'b0;
        end
      end
      RESP: begin
        if (!bus.stall_Mem) begin
          w_state_nx    = IDLE;
          w_dready_n_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_wr_taken  <= 1'b0;
      r_dbusy     <= 1'b0;
      r_dready_n  <= 1'b1;
      r_drdata    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_wptr      <= r_wptr + AW'(w_enq);
      r_rptr      <= r_rptr + AW'(w_deq);
      r_dbusy     <= (w_count_nx == CW'(WBUF_DEPTH));
      r_dready_n  <= w_dready_n_nx;
      r_drdata    <= w_drdata_nx;
      r_mem_req   <= w_mem_req_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_mem_be    <= w_mem_be_nx;
      // A store held by stall_Mem stays on the inputs; enqueue it only once.
      if (!bus.stall_Mem) r_wr_taken <= 1'b0;
      else if (w_enq)     r_wr_taken <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf_addr[r_wptr] <= bus.daddr;
      r_buf_data[r_wptr] <= bus.dwdata;
      r_buf_be[r_wptr]   <= bus.dbe;
    end
  end

  assign bus.dready_n  = r_dready_n;
  assign bus.dbusy     = r_dbusy;
  assign bus.drdata    = r_drdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random store/load traffic against an
// architectural memory model and a randomly-delayed memory responder.
module tb_dmem_responder;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder #(.WBUF_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] be;} wr_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] arch_mem [logic [31:0]];
  logic [31:0] mem_model [logic [31:0]];
  wr_t exp_q [$];
  int n_acc = 0, n_wr = 0, n_rd = 0, n_ld = 0;
  bit load_active = 1'b0;
  bit resp_en = 1'b1;
  bit stale_ack = 1'b0;
  int dly_fixed = 0;
  logic [31:0] last_wa, last_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_arch(input logic [31:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : dflt(a);
  endfunction

  // Memory responder: ack is sampled dly edges after mem_req first rises.
  initial begin : responder
    int cnt;
    bit busy;
    wr_t w;
    cnt = 0;
    busy = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = stale_ack;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (bus.mem_req && !busy && resp_en) begin
          busy = 1'b1;
          cnt = ((dly_fixed > 0) ? dly_fixed : $urandom_range(1, 4)) - 1;
        end
        if (busy && resp_en) begin
          if (cnt == 0) begin
            bus.mem_ack = 1'b1;
            busy = 1'b0;
            if (bus.mem_we) begin
              n_wr++;
              last_wa = bus.mem_addr;
              last_wd = bus.mem_wdata;
              chk1("write_expected", exp_q.size() != 0, 1'b1);
              if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, w.a);
                chk("wr_data", bus.mem_wdata, w.d);
                chk("wr_be", {28'd0, bus.mem_be}, {28'd0, w.be});
              end
              mem_model[bus.mem_addr] = merge(rd_mem(bus.mem_addr), bus.mem_wdata, bus.mem_be);
            end else begin
              n_rd++;
              chk("rd_be", {28'd0, bus.mem_be}, 32'hF);
              bus.mem_rdata = rd_mem(bus.mem_addr);
            end
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model: buffer occupancy, idle dready_n, request stability.
  initial begin : compare
    logic pr, pw;
    logic [31:0] pa, pd;
    logic [3:0] pb;
    pr = 1'b0; pw = 1'b0; pa = '0; pd = '0; pb = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk1("dbusy", bus.dbusy, (n_acc - n_wr) == DEPTH);
        if (!load_active) chk1("dready_n_idle", bus.dready_n, 1'b1);
        if (pr && !bus.mem_ack) begin
          chk1("req_held", bus.mem_req, 1'b1);
          chk1("we_held", bus.mem_we, pw);
          chk("addr_held", bus.mem_addr, pa);
          chk("wdata_held", bus.mem_wdata, pd);
          chk("be_held", {28'd0, bus.mem_be}, {28'd0, pb});
        end
      end
      pr = rst ? 1'b0 : bus.mem_req;
      pw = bus.mem_we; pa = bus.mem_addr; pd = bus.mem_wdata; pb = bus.mem_be;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driver tasks are entered just after a negedge and return just after one.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int stall_cyc);
    int guard;
    wr_t w;
    guard = 0;
    bus.MemRW_pype2 = 2'b01; bus.daddr = a; bus.dwdata = d; bus.dbe = be; bus.stall_Mem = 1'b0;
    while (bus.dbusy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk1("st_accept", bus.dbusy, 1'b0);
    bus.stall_Mem = (stall_cyc > 0);
    n_acc++;
    w.a = a; w.d = d; w.be = be;
    exp_q.push_back(w);
    arch_mem[a] = merge(rd_arch(a), d, be);
    @(negedge clk);
    for (int i = 1; i < stall_cyc; i++) @(negedge clk);
    if (stall_cyc > 0) begin
      bus.stall_Mem = 1'b0;
      @(negedge clk);
    end
    bus.MemRW_pype2 = 2'b00;
  endtask

  task automatic do_load(input logic [31:0] a, input int hold, output logic [31:0] data, output int lat);
    logic [31:0] exp;
    exp = rd_arch(a);
    n_ld++;
    bus.MemRW_pype2 = 2'b10; bus.daddr = a; bus.stall_Mem = 1'b0;
    load_active = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.dready_n && lat < 200);
    chk1("ld_ready", bus.dready_n, 1'b0);
    chk("ld_data", bus.drdata, exp);
    data = bus.drdata;
    if (hold > 0) bus.stall_Mem = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("resp_hold_ready", bus.dready_n, 1'b0);
      chk("resp_hold_data", bus.drdata, data);
    end
    bus.stall_Mem = 1'b0;
    @(negedge clk);
    chk1("resp_release", bus.dready_n, 1'b1);
    bus.MemRW_pype2 = 2'b00;
    load_active = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((n_acc != n_wr || bus.mem_req) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_done", n_acc - n_wr, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin : main
    logic [31:0] d;
    int lat, w0, rd0;
    bus.MemRW_pype2 = 2'b00; bus.daddr = '0; bus.dwdata = '0; bus.dbe = '0; bus.stall_Mem = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk1("rst_dready_n", bus.dready_n, 1'b1);
    chk1("rst_dbusy", bus.dbusy, 1'b0);
    chk("rst_drdata", bus.drdata, 32'h0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single store, ack two edges after request.
    dly_fixed = 2; w0 = n_wr;
    do_store(32'h100, 32'hDEADBEEF, 4'hF, 0);
    wait_drain();
    chk("single_wr_count", n_wr - w0, 1);
    chk("single_wr_addr", last_wa, 32'h100);
    chk("single_wr_data", last_wd, 32'hDEADBEEF);

    // Three back-to-back stores with acks withheld.
    dly_fixed = 1; resp_en = 1'b0; w0 = n_wr;
    fork
      begin
        repeat (4) @(negedge clk);
        chk1("full_dbusy", bus.dbusy, 1'b1);
        chk("full_accepted", n_acc - n_wr, 2);
        resp_en = 1'b1;
      end
    join_none
    do_store(32'h110, 32'h11111111, 4'hF, 0);
    do_store(32'h114, 32'h22222222, 4'hF, 0);
    do_store(32'h118, 32'h33333333, 4'h3, 0);
    chk1("third_after_ack", n_wr - w0 >= 1, 1'b1);
    wait_drain();
    chk("burst_wr_count", n_wr - w0, 3);

    // Load latency with an empty buffer.
    dly_fixed = 3;
    arch_mem[32'h200] = 32'h12345678; mem_model[32'h200] = 32'h12345678;
    do_load(32'h200, 0, d, lat);
    chk("ld_latency", lat, 4);
    chk("ld_value", d, 32'h12345678);

    // Store held under stall_Mem, load held in RESP.
    dly_fixed = 0; w0 = n_wr;
    do_store(32'h180, 32'hCAFEF00D, 4'hF, 5);
    wait_drain();
    chk("stalled_store_once", n_wr - w0, 1);
    do_load(32'h180, 4, d, lat);
    chk("held_ld_value", d, 32'hCAFEF00D);

    // Store then load of the same full word with the write ack withheld.
    dly_fixed = 1; resp_en = 1'b0; rd0 = n_rd;
    do_store(32'h300, 32'hA5A5A5A5, 4'hF, 0);
    fork
      begin
        repeat (6) @(negedge clk);
`ifndef DMEM_WBUF_FWD_EN
        chk("no_read_before_wr_ack", n_rd - rd0, 0);
        chk1("ld_waits_for_drain", bus.dready_n, 1'b1);
`endif
        resp_en = 1'b1;
      end
    join_none
    do_load(32'h300, 0, d, lat);
    chk("raw_ld_value", d, 32'hA5A5A5A5);
`ifdef DMEM_WBUF_FWD_EN
    chk("fwd_no_read", n_rd - rd0, 0);
    chk("fwd_latency", lat, 1);
`else
    chk("read_after_wr", n_rd - rd0, 1);
`endif
    wait_drain();

    // Reset while a read is outstanding, then a stale ack.
    dly_fixed = 8; load_active = 1'b1;
    bus.MemRW_pype2 = 2'b10; bus.daddr = 32'h400;
    repeat (2) @(negedge clk);
    chk1("rd_outstanding", bus.mem_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("mid_rst_req", bus.mem_req, 1'b0);
    chk1("mid_rst_dready_n", bus.dready_n, 1'b1);
    chk("mid_rst_addr", bus.mem_addr, 32'h0);
    chk("mid_rst_be", {28'd0, bus.mem_be}, 32'h0);
    chk("mid_rst_drdata", bus.drdata, 32'h0);
    bus.MemRW_pype2 = 2'b00; load_active = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; stale_ack = 1'b1;
    @(negedge clk);
    stale_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk1("stale_ack_req", bus.mem_req, 1'b0);
    chk1("stale_ack_dready_n", bus.dready_n, 1'b1);
    dly_fixed = 2;
    do_load(32'h400, 0, d, lat);
    chk("fresh_ld_latency", lat, 3);

    // Random traffic.
    dly_fixed = 0;
    for (int k = 0; k < 250; k++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = 32'h1000 + 32'($urandom_range(0, 5)) * 4;
      if (r < 45) begin
        do_store(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end else if (r < 80) begin
        do_load(a, $urandom_range(0, 2), d, lat);
      end else begin
        bus.MemRW_pype2 = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        bus.daddr = a; bus.dwdata = $urandom; bus.dbe = 4'hF;
        bus.stall_Mem = ($urandom_range(0, 1) != 0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.MemRW_pype2 = 2'b00; bus.stall_Mem = 1'b0;
      end
    end
    wait_drain();
`ifdef DMEM_WBUF_FWD_EN
    chk1("reads_le_loads", n_rd <= n_ld, 1'b1);
`else
    chk("reads_eq_loads", n_rd, n_ld);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
